// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
//
// Collects floor-call button presses into a pending mask and hands the
// elevator core one target floor at a time, in SCAN order: keep going in the
// current sweep direction and reverse only when nothing is pending ahead.
//
// Optional feature (compile-time macro SCHED_PREEMPT_EN):
//   defined   - while the car is travelling (WAIT_DONE), a pending floor that
//               lies strictly between cur_floor and tgt_floor in the sweep
//               direction replaces the target with the nearest such floor.
//               The displaced target stays pending; tgt_valid stays high.
//   undefined - tgt_floor is fixed from DISPATCH until move_done.
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high reset
//   call_req     in   [NUM_FLOORS]  per-floor call pulses
//   cur_floor    in   [FLOOR_W]     current car floor from the core
//   move_done    in   core arrival flag (meaningful only in WAIT_DONE)
//   over_weight  in   core over-weight flag, blocks dispatch
//   tgt_floor    out  [FLOOR_W]     target floor presented to the core
//   tgt_valid    out  tgt_floor is a live command
//   pending      out  [NUM_FLOORS]  registered pending-call mask
//   sweep_up     out  current sweep direction, 1 = up
//   busy         out  high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3,
  parameter int DOOR_HOLD  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  move_done,
  input  logic                  over_weight,
  output logic [FLOOR_W-1:0]    tgt_floor,
  output logic                  tgt_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  sweep_up,
  output logic                  busy
);

  localparam int CNT_W = (DOOR_HOLD < 1) ? 1 : $clog2(DOOR_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DOOR_HOLD);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DISPATCH,
    WAIT_DONE,
    DOOR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] door_cnt;

  // One-hot mask of a floor index; an out-of-range floor yields an empty
  // mask so it can never clear or match a pending bit.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    floor_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (int'(f) == i) floor_mask[i] = 1'b1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational helpers: floor masks and SCAN candidate search
  // ---------------------------------------------------------------------------
  int                    cur_i;
  logic                  cur_valid;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] tgt_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic                  above_found;
  logic [FLOOR_W-1:0]    above_floor;
  logic                  below_found;
  logic [FLOOR_W-1:0]    below_floor;

  assign cur_mask = floor_mask(cur_floor);
  assign tgt_mask = floor_mask(tgt_floor);

  // NOTE: every signal written in always_comb gets a default at the top, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cur_i       = int'(cur_floor);
    cur_valid   = (cur_i < NUM_FLOORS);

    // Nearest pending floor above: scan top-down, the last hit is the lowest.
    above_found = 1'b0;
    above_floor = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > cur_i)) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end

    // Nearest pending floor below: scan bottom-up, the last hit is the highest.
    below_found = 1'b0;
    below_floor = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < cur_i)) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
      end
    end
  end

  // Bits removed from pending this cycle. The car's own floor is cleared while
  // it stands (IDLE/DOOR); the target is cleared on arrival. The clear is
  // applied after the OR with call_req, so it wins over a same-cycle call.
  always_comb begin
    clr_mask = '0;
    case (state)
      IDLE, DOOR: if (cur_valid) clr_mask = cur_mask;
      WAIT_DONE:  if (move_done) clr_mask = tgt_mask;
      default:    clr_mask = '0;
    endcase
  end

`ifdef SCHED_PREEMPT_EN
  // Nearest pending floor strictly between the car and its target, looking
  // only in the sweep direction.
  int                 tgt_i;
  logic               pre_found;
  logic [FLOOR_W-1:0] pre_floor;

  always_comb begin
    tgt_i     = int'(tgt_floor);
    pre_found = 1'b0;
    pre_floor = '0;
    if (cur_valid) begin
      if (sweep_up) begin
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
          if (pending[i] && (i > cur_i) && (i < tgt_i)) begin
            pre_found = 1'b1;
            pre_floor = FLOOR_W'(i);
          end
        end
      end else begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
          if (pending[i] && (i < cur_i) && (i > tgt_i)) begin
            pre_found = 1'b1;
            pre_floor = FLOOR_W'(i);
          end
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      tgt_floor <= '0;
      tgt_valid <= 1'b0;
      sweep_up  <= 1'b1;
      door_cnt  <= '0;
    end else begin
      pending <= (pending | call_req) & ~clr_mask;

      case (state)
        IDLE: begin
          // With an invalid cur_floor nothing can be decided; wait here.
          if (cur_valid) begin
            if (|((call_req | pending) & cur_mask)) begin
              door_cnt <= HOLD_LOAD;
              state    <= DOOR;
            end else if (|(call_req | pending)) begin
              state <= SELECT;
            end
          end
        end

        SELECT: begin
          if (!cur_valid) begin
            state <= IDLE;
          end else if (sweep_up ? above_found : below_found) begin
            tgt_floor <= sweep_up ? above_floor : below_floor;
            state     <= DISPATCH;
          end else if (sweep_up ? below_found : above_found) begin
            // Nothing ahead: reverse the sweep and take the nearest behind.
            tgt_floor <= sweep_up ? below_floor : above_floor;
            sweep_up  <= ~sweep_up;
            state     <= DISPATCH;
          end else begin
            // Only the car's own floor (or nothing) is pending; IDLE opens
            // the door for it on the next cycle.
            state <= IDLE;
          end
        end

        DISPATCH: begin
          if (!over_weight && cur_valid) begin
            tgt_valid <= 1'b1;
            state     <= WAIT_DONE;
          end
        end

        WAIT_DONE: begin
          if (move_done) begin
            tgt_valid <= 1'b0;
            door_cnt  <= HOLD_LOAD;
            state     <= DOOR;
          end
`ifdef SCHED_PREEMPT_EN
          else if (pre_found) begin
            tgt_floor <= pre_floor;
          end
`endif
        end

        DOOR: begin
          // The door stays open exactly DOOR_HOLD cycles after the last call
          // at this floor.
          if (cur_valid && |(call_req & cur_mask)) begin
            door_cnt <= HOLD_LOAD;
          end else if (door_cnt <= CNT_W'(1)) begin
            door_cnt <= '0;
            state    <= (|pending) ? SELECT : IDLE;
          end else begin
            door_cnt <= door_cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
- Collects floor-call button presses, holds them as a pending mask, and issues one target floor at a time to the elevator core.
- Dispatch order is SCAN: continue in the current sweep direction, reverse only when no calls remain ahead.
- Sits in front of the elevator core: drives its requested-floor input, consumes its completion and over-weight flags and its current-floor output.

Parameters:
- NUM_FLOORS, 8, number of served floors; one pending bit per floor.
- FLOOR_W, 3, width of floor indices; requires 2**FLOOR_W >= NUM_FLOORS.
- DOOR_HOLD, 4, cycles spent in DOOR state after each arrival.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- call_req  in  NUM_FLOORS  per-floor call pulses; bit i set = call at floor i.
- cur_floor  in  FLOOR_W  current car floor from the elevator core.
- move_done  in  1  core completion flag; arrival at tgt_floor.
- over_weight  in  1  core over-weight flag; blocks dispatch.
- tgt_floor  out  FLOOR_W  target floor presented to the core.
- tgt_valid  out  1  tgt_floor is a live command.
- pending  out  NUM_FLOORS  registered pending-call mask.
- sweep_up  out  1  current sweep direction; 1 = up.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous): state IDLE, pending=0, tgt_floor=0, tgt_valid=0, sweep_up=1, busy=0, door counter=0. Reset in any state (including WAIT_DONE) discards all pending calls and the live target on that edge.
- Pending update: pending <= (pending | call_req) & ~clr. clr is the arrival bit, or the cur_floor bit in IDLE/DOOR. Clear wins over a same-cycle call to the same floor.
- States: IDLE, SELECT, DISPATCH, WAIT_DONE, DOOR.
- IDLE:
  - Call at cur_floor (in call_req or pending): clear it, go to DOOR and load the counter with DOOR_HOLD.
  - Else, pending != 0: go to SELECT.
- SELECT (1 cycle): register tgt_floor.
  - sweep_up=1: lowest pending floor > cur_floor. If none, highest pending floor < cur_floor, and sweep_up <= 0.
  - sweep_up=0: mirror image of the above.
  - Then go to DISPATCH.
- DISPATCH: while over_weight=1, hold with tgt_valid=0. When over_weight=0, set tgt_valid=1 and go to WAIT_DONE.
- Latency: call pulse at cycle N → pending visible N+1 → SELECT N+1 → tgt_valid=1 at N+3 (no over-weight).
- WAIT_DONE:
  - tgt_valid held at 1, tgt_floor stable (see the optional feature).
  - over_weight is ignored here.
  - On move_done: tgt_valid <= 0, clear pending[tgt_floor], load counter with DOOR_HOLD, go to DOOR.
- DOOR:
  - Decrement the counter each cycle.
  - A call at cur_floor is cleared and reloads the counter with DOOR_HOLD.
  - When the counter reaches 0: go to SELECT if pending != 0, else IDLE.
- Boundary rules:
  - move_done outside WAIT_DONE is ignored.
  - cur_floor >= NUM_FLOORS: no selection is made; the block stays in IDLE or DISPATCH until cur_floor is valid.
  - Floor 0 and floor NUM_FLOORS-1 are ends of sweep; direction reversal happens only in SELECT.

Optional Feature:
- Macro: SCHED_PREEMPT_EN.
- Defined: in WAIT_DONE, if a pending floor lies strictly between cur_floor and tgt_floor in the sweep direction, tgt_floor is updated on the next edge to the nearest such floor. tgt_valid stays 1 throughout. The displaced target remains pending.
- Undefined: tgt_floor is fixed from DISPATCH until move_done.

Test Plan:
- Reset, cur_floor=0, call_req=8'h40 for 1 cycle (call cycle N) → pending=8'h40 at N+1; tgt_floor=6, tgt_valid=1 at N+3. Pulse move_done with cur_floor=6 → pending=0, tgt_valid=0; busy=1 for 4 cycles, then IDLE with busy=0.
- cur_floor=3, sweep_up=1, calls to floors 1, 5, 7 → dispatch order 5, 7, 1; sweep_up goes to 0 in the SELECT that picks floor 1.
- over_weight=1 through DISPATCH with target 4 → tgt_valid stays 0 and state holds. Deassert → tgt_valid=1 on the next edge.
- IDLE, cur_floor=2, call_req bit 2 → no dispatch (tgt_valid=0), pending[2]=0 afterwards, busy=1 for DOOR_HOLD cycles. Repeat the call mid-DOOR → counter reloads to 4.
- In WAIT_DONE with pending=8'h24, assert reset for 1 cycle → pending=0, tgt_valid=0, sweep_up=1, busy=0 after that edge; later move_done is ignored.
- SCHED_PREEMPT_EN defined: cur_floor=0, tgt_floor=6 in WAIT_DONE, call floor 3 → tgt_floor=3 two edges after the call, pending[6] still 1. Macro undefined → tgt_floor stays 6.
